path_delay_sequencer: RTL and testbench
=======================================

# path_delay_sequencer

Sequences delay tests on a bank of chained delay paths used for delay-based Trojan detection. For each selected path, it repeatedly launches a transition into the path input and samples the path output a programmed number of clock cycles later. It counts late or stuck captures and reports a per-path fail count and a threshold flag. It sits between the host/UART command logic and the instantiated delay-path chains, and is the only driver of their path inputs.

## Interface
Parameters:
- NUM_PATHS, 4, number of delay-path chains under control
- TRIAL_W, 16, width of trial count and fail counters
- DLY_W, 8, width of capture-delay setting
- SETTLE_CYC, 16, cycles the launch input is held at its idle level before each launch

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; accepted only while idle
- path_mask  in  NUM_PATHS  paths to test; sampled at start
- num_trials  in  TRIAL_W  trials per path; sampled at start; 0 treated as 1
- capture_dly  in  DLY_W  launch-to-capture cycles; sampled at start; 0 treated as 1
- fail_thresh  in  TRIAL_W  flag threshold; sampled at start
- path_launch  out  NUM_PATHS  registered drive to each path input
- path_result  in  NUM_PATHS  raw path outputs, asynchronous to clk
- busy  out  1  high from the cycle after start until done
- res_valid  out  1  one-cycle pulse per finished path
- res_path  out  $clog2(NUM_PATHS)  index of reported path
- res_fails  out  TRIAL_W  fail count of reported path
- res_flag  out  1  res_fails >= fail_thresh
- stuck_err  out  1  sticky; path output not at idle level after settle; cleared at start

## Operation
- States: IDLE, SELECT, SETTLE, LAUNCH, WAIT, CAPTURE, REPORT, DONE.
- IDLE: when start and rst low, latch the configuration, clear stuck_err, set the path pointer to 0, and go to SELECT.
- SELECT: scan upward from the pointer for the next set mask bit. If one is found, clear the fail counter and trial counter and go to SETTLE. If none, go to DONE. A mask of 0 goes straight to DONE with no res_valid.
- SETTLE:
  - Hold the selected launch bit at 0 for SETTLE_CYC cycles.
  - On the last cycle, if the synchronized path_result bit is not 0, set stuck_err and count this trial as a fail.
- LAUNCH: drive the selected launch bit to 1 (a rising transition).
- WAIT: count capture_dly cycles.
- CAPTURE:
  - Register the raw path_result into the capture flop. This flop is the measurement point and is intentionally unsynchronized.
  - A 0 is a fail; the fail counter saturates at all-ones.
  - Increment the trial counter. If the count is below num_trials, go to SETTLE; otherwise go to REPORT.
- REPORT: pulse res_valid with res_path, res_fails and res_flag, then advance the pointer and go to SELECT.
- DONE: busy drops and the block returns to IDLE.
- Only the selected path's launch bit ever goes high. All other launch bits stay 0.
- start while busy is ignored.
- rst mid-test: all launch bits go to 0 on the next edge and the block enters IDLE; no res_valid is issued for the interrupted path.

## Timing
- Reset values: path_launch 0, busy 0, res_valid 0, res_path 0, res_fails 0, res_flag 0, stuck_err 0.
- Let edge L be the clock edge where path_launch rises. The capture flop samples path_result on edge L + capture_dly (after 0→1 substitution). So capture_dly = 1 means a one-period delay budget.
- The launch bit falls on the edge after capture, and a new SETTLE starts on that same edge.
- Trial period = SETTLE_CYC + capture_dly + 2 cycles.
- res_valid follows the last capture of a path by 1 cycle. res_* hold their values until the next res_valid.
- busy goes high on the edge after start and falls on the edge after the last REPORT (or after SELECT when no path is left).
- The stuck check uses a 2-flop synchronizer on path_result; the capture flop does not.

## Configuration
- PATH_DLY_FALLING_EN defined: each trial also tests the falling edge.
  - After the rising capture, the launch bit is held at 1 for SETTLE_CYC cycles. If the synchronized output is not 1, stuck_err is set.
  - The launch bit is then driven to 0, and the capture flop samples after capture_dly cycles; a 1 is a fail.
  - A trial is counted as failed if either edge fails, so the fail counter increments at most once per trial.
  - Trial period doubles.
- Undefined: rising-edge tests only, exactly as in Operation.

## Structure
- Package path_dly_pkg holds:
  - the state enum;
  - helper constant PATH_IDX_W = $clog2(NUM_PATHS), with a minimum of 1.
- One sub-module, path_dly_capture: the per-path raw capture flop plus the 2-flop synchronizer. It is instantiated NUM_PATHS times, and the sequencer muxes the selected path's outputs.

## Test plan
- Fast path model (output follows launch after 2 cycles), mask=4'b0001, trials=10, capture_dly=4 → one res_valid with res_path=0, res_fails=0, res_flag=0.
- Same model with capture_dly=1, thresh=5 → res_fails=10, res_flag=1.
- Path model stuck at 1, mask=4'b0010, trials=3 → stuck_err=1 and res_path=1 with res_fails=3; launch bits 0, 2 and 3 never go high.
- mask=4'b1010, trials=2 → exactly two res_valid pulses with res_path 1 then 3; mask=0 → busy for at most 2 cycles and no res_valid.
- rst asserted during WAIT → path_launch=0 on the next edge, busy=0, no res_valid; a subsequent start runs normally.
- PATH_DLY_FALLING_EN with a model whose falling edge is 6 cycles and rising edge is 2 cycles, capture_dly=4 → every trial fails, res_fails = num_trials.

Source files
------------

// File: rtl/path_dly_pkg.sv
// Shared types and helpers for the path-delay sequencer slice.
// Holds the sequencer state encoding and the path-index width helper.
package path_dly_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        LAUNCH,
        WAIT,
        CAPTURE,
        REPORT,
        DONE
    } seqState_e;

    // $clog2 of 1 is 0, but a path index always needs at least one bit.
    function automatic int idxWidth(input int numPaths);
        return (numPaths > 2) ? $clog2(numPaths) : 1;
    endfunction

    localparam int NUM_PATHS_DEF = 4;
    localparam int PATH_IDX_W    = idxWidth(NUM_PATHS_DEF);

endpackage

// File: rtl/path_delay_sequencer_if.sv
// Command/result bus between the host command logic (master) and the
// path-delay sequencer (slave).
interface path_delay_sequencer_if #(
    parameter int NUM_PATHS = 4,
    parameter int TRIAL_W   = 16,
    parameter int DLY_W     = 8
);
    import path_dly_pkg::*;

    localparam int IDX_W = idxWidth(NUM_PATHS);

    logic                 start;
    logic [NUM_PATHS-1:0] path_mask;
    logic [TRIAL_W-1:0]   num_trials;
    logic [DLY_W-1:0]     capture_dly;
    logic [TRIAL_W-1:0]   fail_thresh;
    logic                 busy;
    logic                 res_valid;
    logic [IDX_W-1:0]     res_path;
    logic [TRIAL_W-1:0]   res_fails;
    logic                 res_flag;
    logic                 stuck_err;

    modport master (
        output start, path_mask, num_trials, capture_dly, fail_thresh,
        input  busy, res_valid, res_path, res_fails, res_flag, stuck_err
    );

    modport slave (
        input  start, path_mask, num_trials, capture_dly, fail_thresh,
        output busy, res_valid, res_path, res_fails, res_flag, stuck_err
    );

endinterface

// File: rtl/path_dly_capture.sv
// Per-path measurement front end: an enabled raw capture flop (the timing
// measurement point, deliberately unsynchronized) and a 2-flop synchronizer.
module path_dly_capture (
    input  logic clk,
    input  logic rst,
    input  logic capEn,
    input  logic pathResult,
    output logic capQ,
    output logic syncQ
);

    logic syncMeta;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            capQ     <= 1'b0;
            syncMeta <= 1'b0;
            syncQ    <= 1'b0;
        end else begin
            if (capEn) begin
                capQ <= pathResult;
            end
            syncMeta <= pathResult;
            syncQ    <= syncMeta;
        end
    end

endmodule

// File: rtl/path_delay_sequencer.sv
// Launches transitions into selected delay paths and counts late/stuck
// captures per path. Define PATH_DLY_FALLING_EN to also test the falling edge.
module path_delay_sequencer #(
    parameter int NUM_PATHS  = 4,
    parameter int TRIAL_W    = 16,
    parameter int DLY_W      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    path_delay_sequencer_if.slave cmd,
    output logic [NUM_PATHS-1:0] path_launch,
    input  logic [NUM_PATHS-1:0] path_result
);
    import path_dly_pkg::*;

    localparam int IDX_W = idxWidth(NUM_PATHS);
    localparam int PTR_W = IDX_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
`ifdef PATH_DLY_FALLING_EN
    localparam bit FALLING_EN = 1'b1;
`else
    localparam bit FALLING_EN = 1'b0;
`endif

    seqState_e            state;
    logic [NUM_PATHS-1:0] mask;
    logic [TRIAL_W-1:0]   trials;
    logic [TRIAL_W-1:0]   thresh;
    logic [TRIAL_W-1:0]   failCnt;
    logic [TRIAL_W-1:0]   trialCnt;
    logic [DLY_W-1:0]     dly;
    logic [DLY_W-1:0]     dlyCnt;
    logic [SET_W-1:0]     settleCnt;
    logic [PTR_W-1:0]     ptr;
    logic [IDX_W-1:0]     sel;
    logic                 trialFail;
    logic                 fallPhase;

    logic [NUM_PATHS-1:0] capQ;
    logic [NUM_PATHS-1:0] syncQ;
    logic                 capEn;
    logic                 selCap;
    logic                 selSync;
    logic                 capFail;
    logic                 lastEdge;
    logic                 found;
    logic [IDX_W-1:0]     nextIdx;

    for (genvar i = 0; i < NUM_PATHS; i++) begin : gCap
        path_dly_capture uCap (
            .clk        (clk),
            .rst        (rst),
            .capEn      (capEn),
            .pathResult (path_result[i]),
            .capQ       (capQ[i]),
            .syncQ      (syncQ[i])
        );
    end

    // The capture flop samples on edge L + dly, the last WAIT edge.
    assign capEn    = (state == WAIT) && (dlyCnt == dly);
    assign selCap   = capQ[sel];
    assign selSync  = syncQ[sel];
    assign capFail  = fallPhase ? selCap : ~selCap;
    assign lastEdge = !FALLING_EN || fallPhase;

    // Lowest set mask bit at or above the pointer.
    always_comb begin
        // NOTE: every output gets a default first, so no latch is inferred.
        found   = 1'b0;
        nextIdx = '0;
        for (int i = NUM_PATHS - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= ptr)) begin
                found   = 1'b1;
                nextIdx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            path_launch   <= '0;
            mask          <= '0;
            trials        <= '0;
            thresh        <= '0;
            failCnt       <= '0;
            trialCnt      <= '0;
            dly           <= '0;
            dlyCnt        <= '0;
            settleCnt     <= '0;
            ptr           <= '0;
            sel           <= '0;
            trialFail     <= 1'b0;
            fallPhase     <= 1'b0;
            cmd.busy      <= 1'b0;
            cmd.res_valid <= 1'b0;
            cmd.res_path  <= '0;
            cmd.res_fails <= '0;
            cmd.res_flag  <= 1'b0;
            cmd.stuck_err <= 1'b0;
        end else begin
            cmd.res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.start) begin
                        mask          <= cmd.path_mask;
                        trials        <= (cmd.num_trials == '0) ? TRIAL_W'(1) : cmd.num_trials;
                        dly           <= (cmd.capture_dly == '0) ? DLY_W'(1) : cmd.capture_dly;
                        thresh        <= cmd.fail_thresh;
                        ptr           <= '0;
                        cmd.stuck_err <= 1'b0;
                        cmd.busy      <= 1'b1;
                        state         <= SELECT;
                    end
                end
                SELECT: begin
                    if (found) begin
                        sel       <= nextIdx;
                        failCnt   <= '0;
                        trialCnt  <= '0;
                        trialFail <= 1'b0;
                        fallPhase <= 1'b0;
                        settleCnt <= '0;
                        state     <= SETTLE;
                    end else begin
                        cmd.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                SETTLE: begin
                    // The path output must have settled at the launch level.
                    if (settleCnt == SETTLE_LAST) begin
                        if (selSync != fallPhase) begin
                            cmd.stuck_err <= 1'b1;
                            trialFail     <= 1'b1;
                        end
                        state <= LAUNCH;
                    end else begin
                        settleCnt <= settleCnt + SET_W'(1);
                    end
                end
                LAUNCH: begin
                    path_launch <= fallPhase ? '0 : (NUM_PATHS'(1) << sel);
                    dlyCnt      <= DLY_W'(1);
                    state       <= WAIT;
                end
                WAIT: begin
                    if (dlyCnt == dly) begin
                        state <= CAPTURE;
                    end else begin
                        dlyCnt <= dlyCnt + DLY_W'(1);
                    end
                end
                CAPTURE: begin
                    settleCnt <= '0;
                    if (!lastEdge) begin
                        // Launch stays high; the falling half of the trial follows.
                        trialFail <= trialFail | capFail;
                        fallPhase <= 1'b1;
                        state     <= SETTLE;
                    end else begin
                        if ((trialFail || capFail) && (failCnt != '1)) begin
                            failCnt <= failCnt + TRIAL_W'(1);
                        end
                        trialFail   <= 1'b0;
                        fallPhase   <= 1'b0;
                        path_launch <= '0;
                        trialCnt    <= trialCnt + TRIAL_W'(1);
                        state       <= ((trialCnt + TRIAL_W'(1)) < trials) ? SETTLE : REPORT;
                    end
                end
                REPORT: begin
                    cmd.res_valid <= 1'b1;
                    cmd.res_path  <= sel;
                    cmd.res_fails <= failCnt;
                    cmd.res_flag  <= (failCnt >= thresh);
                    ptr           <= PTR_W'(sel) + PTR_W'(1);
                    state         <= SELECT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_sequencer.sv
// Directed bench for path_delay_sequencer with a behavioural delay-path model
// per path (fast, stuck-at-1, or slow falling edge).
module tb_path_delay_sequencer;

    localparam int NP = 4;
    localparam int TW = 16;
    localparam int DW = 8;
    localparam int SC = 16;
`ifdef PATH_DLY_FALLING_EN
    localparam int PHASES = 2;
`else
    localparam int PHASES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] path_launch;
    logic [NP-1:0] path_result;

    path_delay_sequencer_if #(.NUM_PATHS(NP), .TRIAL_W(TW), .DLY_W(DW)) bus ();

    path_delay_sequencer #(
        .NUM_PATHS (NP),
        .TRIAL_W   (TW),
        .DLY_W     (DW),
        .SETTLE_CYC(SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .path_launch(path_launch),
        .path_result(path_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Path model: hist[i][k] is the launch value sampled k+1 edges ago.
    // mode 0: output = launch delayed 2 cycles; 1: stuck at 1;
    // 2: rises 2 cycles after launch, falls 6 cycles after launch drops.
    logic [5:0] hist [NP];
    int         pathMode [NP];

    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (rst) hist[i] <= '0;
            else     hist[i] <= {hist[i][4:0], path_launch[i]};
        end
    end

    always_comb begin
        path_result = '0;
        for (int i = 0; i < NP; i++) begin
            case (pathMode[i])
                1:       path_result[i] = 1'b1;
                2:       path_result[i] = |hist[i][5:1];
                default: path_result[i] = hist[i][1];
            endcase
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    // Records of the most recent run.
    int rvCount;
    int rvPath [8];
    int rvFails [8];
    int rvFlag [8];
    int firstValidCyc;
    int firstLaunchCyc;
    int busyCycles;
    int launchViolations;

    function automatic int period(input int d);
        int de;
        de = (d == 0) ? 1 : d;
        return PHASES * (SC + de + 2);
    endfunction

    task automatic sampleOutputs(input int s, input logic [NP-1:0] mask);
        if (bus.busy) busyCycles++;
        if ((path_launch & ~mask) != '0 || $countones(path_launch) > 1) launchViolations++;
        if (firstLaunchCyc < 0 && path_launch != '0) firstLaunchCyc = cyc - s;
        if (bus.res_valid) begin
            if (rvCount < 8) begin
                rvPath[rvCount]  = int'(bus.res_path);
                rvFails[rvCount] = int'(bus.res_fails);
                rvFlag[rvCount]  = int'(bus.res_flag);
            end
            if (firstValidCyc < 0) firstValidCyc = cyc - s;
            rvCount++;
        end
    endtask

    task automatic runSeq(input logic [NP-1:0] mask, input int trials, input int dly, input int thresh);
        int  s;
        bit  done;
        rvCount          = 0;
        firstValidCyc    = -1;
        firstLaunchCyc   = -1;
        busyCycles       = 0;
        launchViolations = 0;
        @(negedge clk);
        bus.path_mask   = mask;
        bus.num_trials  = TW'(trials);
        bus.capture_dly = DW'(dly);
        bus.fail_thresh = TW'(thresh);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s    = cyc;
        done = 1'b0;
        for (int n = 0; n < 20000 && !done; n++) begin
            sampleOutputs(s, mask);
            if (!bus.busy) done = 1'b1;
            else @(negedge clk);
        end
        nChecks++;
        if (!done) begin
            $display("FAIL run_timeout: busy still %0b after 20000 cycles, required 0", bus.busy);
            nFails++;
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            sampleOutputs(s, mask);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks += 7;
        if (path_launch !== '0)    begin $display("FAIL reset_launch: got %b required 0", path_launch); nFails++; end
        if (bus.busy !== 1'b0)      begin $display("FAIL reset_busy: got %b required 0", bus.busy); nFails++; end
        if (bus.res_valid !== 1'b0) begin $display("FAIL reset_res_valid: got %b required 0", bus.res_valid); nFails++; end
        if (bus.res_path !== '0)    begin $display("FAIL reset_res_path: got %0d required 0", bus.res_path); nFails++; end
        if (bus.res_fails !== '0)   begin $display("FAIL reset_res_fails: got %0d required 0", bus.res_fails); nFails++; end
        if (bus.res_flag !== 1'b0)  begin $display("FAIL reset_res_flag: got %b required 0", bus.res_flag); nFails++; end
        if (bus.stuck_err !== 1'b0) begin $display("FAIL reset_stuck_err: got %b required 0", bus.stuck_err); nFails++; end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fast_pass();
        runSeq(4'b0001, 10, 4, 5);
        nChecks += 8;
        if (rvCount != 1)       begin $display("FAIL pass_valid_count: got %0d required 1", rvCount); nFails++; end
        if (rvPath[0] != 0)     begin $display("FAIL pass_path: got %0d required 0", rvPath[0]); nFails++; end
        if (rvFails[0] != 0)    begin $display("FAIL pass_fails: got %0d required 0", rvFails[0]); nFails++; end
        if (rvFlag[0] != 0)     begin $display("FAIL pass_flag: got %0d required 0", rvFlag[0]); nFails++; end
        if (firstLaunchCyc != SC + 2) begin $display("FAIL pass_launch_cycle: got %0d required %0d", firstLaunchCyc, SC + 2); nFails++; end
        if (firstValidCyc != 10 * period(4) + 2) begin
            $display("FAIL pass_valid_cycle: got %0d required %0d", firstValidCyc, 10 * period(4) + 2); nFails++;
        end
        if (launchViolations != 0) begin $display("FAIL pass_launch_bits: got %0d bad cycles required 0", launchViolations); nFails++; end
        if (bus.stuck_err !== 1'b0) begin $display("FAIL pass_stuck: got %b required 0", bus.stuck_err); nFails++; end
    endtask

    task automatic test_fast_fail();
        runSeq(4'b0001, 10, 1, 5);
        nChecks += 3;
        if (rvFails[0] != 10) begin $display("FAIL dly1_fails: got %0d required 10", rvFails[0]); nFails++; end
        if (rvFlag[0] != 1)   begin $display("FAIL dly1_flag: got %0d required 1", rvFlag[0]); nFails++; end
        if (firstValidCyc != 10 * period(1) + 2) begin
            $display("FAIL dly1_valid_cycle: got %0d required %0d", firstValidCyc, 10 * period(1) + 2); nFails++;
        end
        // capture_dly of 0 behaves exactly like 1
        runSeq(4'b0001, 10, 0, 11);
        nChecks += 3;
        if (rvFails[0] != 10) begin $display("FAIL dly0_fails: got %0d required 10", rvFails[0]); nFails++; end
        if (rvFlag[0] != 0)   begin $display("FAIL dly0_flag: got %0d required 0", rvFlag[0]); nFails++; end
        if (firstValidCyc != 10 * period(0) + 2) begin
            $display("FAIL dly0_valid_cycle: got %0d required %0d", firstValidCyc, 10 * period(0) + 2); nFails++;
        end
        repeat (5) @(negedge clk);
        nChecks++;
        if (bus.res_fails !== TW'(10)) begin $display("FAIL res_hold: got %0d required 10", bus.res_fails); nFails++; end
    endtask

    task automatic test_capture_boundary();
        runSeq(4'b0001, 4, 2, 4);
        nChecks += 2;
        if (rvFails[0] != 4) begin $display("FAIL dly2_fails: got %0d required 4", rvFails[0]); nFails++; end
        if (rvFlag[0] != 1)  begin $display("FAIL dly2_flag: got %0d required 1", rvFlag[0]); nFails++; end
        runSeq(4'b0001, 4, 3, 1);
        nChecks += 2;
        if (rvFails[0] != 0) begin $display("FAIL dly3_fails: got %0d required 0", rvFails[0]); nFails++; end
        if (rvFlag[0] != 0)  begin $display("FAIL dly3_flag: got %0d required 0", rvFlag[0]); nFails++; end
        // num_trials of 0 runs a single trial
        runSeq(4'b0001, 0, 4, 0);
        nChecks += 4;
        if (rvCount != 1)    begin $display("FAIL trials0_count: got %0d required 1", rvCount); nFails++; end
        if (rvFails[0] != 0) begin $display("FAIL trials0_fails: got %0d required 0", rvFails[0]); nFails++; end
        if (rvFlag[0] != 1)  begin $display("FAIL trials0_flag: got %0d required 1", rvFlag[0]); nFails++; end
        if (firstValidCyc != period(4) + 2) begin
            $display("FAIL trials0_valid_cycle: got %0d required %0d", firstValidCyc, period(4) + 2); nFails++;
        end
    endtask

    task automatic test_stuck();
        pathMode[1] = 1;
        runSeq(4'b0010, 3, 4, 2);
        nChecks += 6;
        if (bus.stuck_err !== 1'b1) begin $display("FAIL stuck_err: got %b required 1", bus.stuck_err); nFails++; end
        if (rvCount != 1)    begin $display("FAIL stuck_count: got %0d required 1", rvCount); nFails++; end
        if (rvPath[0] != 1)  begin $display("FAIL stuck_path: got %0d required 1", rvPath[0]); nFails++; end
        if (rvFails[0] != 3) begin $display("FAIL stuck_fails: got %0d required 3", rvFails[0]); nFails++; end
        if (rvFlag[0] != 1)  begin $display("FAIL stuck_flag: got %0d required 1", rvFlag[0]); nFails++; end
        if (launchViolations != 0) begin $display("FAIL stuck_launch_bits: got %0d bad cycles required 0", launchViolations); nFails++; end
        pathMode[1] = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_multi_mask();
        runSeq(4'b1010, 2, 4, 1);
        nChecks += 7;
        if (rvCount != 2)    begin $display("FAIL multi_count: got %0d required 2", rvCount); nFails++; end
        if (rvPath[0] != 1)  begin $display("FAIL multi_path0: got %0d required 1", rvPath[0]); nFails++; end
        if (rvPath[1] != 3)  begin $display("FAIL multi_path1: got %0d required 3", rvPath[1]); nFails++; end
        if (rvFails[0] != 0) begin $display("FAIL multi_fails0: got %0d required 0", rvFails[0]); nFails++; end
        if (rvFails[1] != 0) begin $display("FAIL multi_fails1: got %0d required 0", rvFails[1]); nFails++; end
        if (bus.stuck_err !== 1'b0) begin $display("FAIL multi_stuck_cleared: got %b required 0", bus.stuck_err); nFails++; end
        if (launchViolations != 0) begin $display("FAIL multi_launch_bits: got %0d bad cycles required 0", launchViolations); nFails++; end
    endtask

    task automatic test_zero_mask();
        runSeq(4'b0000, 5, 4, 1);
        nChecks += 2;
        if (rvCount != 0) begin $display("FAIL zero_mask_valid: got %0d required 0", rvCount); nFails++; end
        if (busyCycles < 1 || busyCycles > 2) begin
            $display("FAIL zero_mask_busy: got %0d cycles required 1..2", busyCycles); nFails++;
        end
    endtask

    task automatic test_rst_mid();
        bit hit;
        int seen;
        @(negedge clk);
        bus.path_mask   = 4'b0001;
        bus.num_trials  = TW'(5);
        bus.capture_dly = DW'(8);
        bus.fail_thresh = TW'(1);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (path_launch != '0) hit = 1'b1;
            else @(negedge clk);
        end
        nChecks++;
        if (!hit) begin $display("FAIL rst_mid_launch_timeout: launch %b required nonzero", path_launch); nFails++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nChecks += 3;
        if (path_launch !== '0)     begin $display("FAIL rst_mid_launch: got %b required 0", path_launch); nFails++; end
        if (bus.busy !== 1'b0)      begin $display("FAIL rst_mid_busy: got %b required 0", bus.busy); nFails++; end
        if (bus.res_valid !== 1'b0) begin $display("FAIL rst_mid_valid: got %b required 0", bus.res_valid); nFails++; end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        nChecks++;
        if (seen != 0) begin $display("FAIL rst_mid_no_report: got %0d pulses required 0", seen); nFails++; end
        runSeq(4'b0001, 2, 4, 1);
        nChecks += 2;
        if (rvCount != 1)    begin $display("FAIL rst_mid_rerun_count: got %0d required 1", rvCount); nFails++; end
        if (rvFails[0] != 0) begin $display("FAIL rst_mid_rerun_fails: got %0d required 0", rvFails[0]); nFails++; end
    endtask

    task automatic test_falling();
        int expFails;
        // Slow falling edge only matters when the falling half is tested.
        expFails    = (PHASES == 2) ? 3 : 0;
        pathMode[2] = 2;
        runSeq(4'b0100, 3, 4, 3);
        nChecks += 5;
        if (rvPath[0] != 2) begin $display("FAIL fall_path: got %0d required 2", rvPath[0]); nFails++; end
        if (rvFails[0] != expFails) begin $display("FAIL fall_fails: got %0d required %0d", rvFails[0], expFails); nFails++; end
        if (rvFlag[0] != ((expFails >= 3) ? 1 : 0)) begin
            $display("FAIL fall_flag: got %0d required %0d", rvFlag[0], (expFails >= 3) ? 1 : 0); nFails++;
        end
        if (bus.stuck_err !== 1'b0) begin $display("FAIL fall_stuck: got %b required 0", bus.stuck_err); nFails++; end
        if (firstValidCyc != 3 * period(4) + 2) begin
            $display("FAIL fall_valid_cycle: got %0d required %0d", firstValidCyc, 3 * period(4) + 2); nFails++;
        end
        pathMode[2] = 0;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) pathMode[i] = 0;
        bus.start       = 1'b0;
        bus.path_mask   = '0;
        bus.num_trials  = '0;
        bus.capture_dly = '0;
        bus.fail_thresh = '0;
        test_reset();
        test_fast_pass();
        test_fast_fail();
        test_capture_boundary();
        test_stuck();
        test_multi_mask();
        test_zero_mask();
        test_rst_mid();
        test_falling();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
